// File: rtl/matrix_load_pkg.sv
// Shared types and helpers for the matrix weight-load scheduler.
// The index width matches the storage write-port index width.
package matrix_load_pkg;

  localparam int IDX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [IDX_W-1:0] clamp_layers(input logic [IDX_W-1:0] n,
                                                    input logic [IDX_W-1:0] lim);
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/matrix_load_index_counter.sv
// Row/layer index counter: row wraps at size-1 and bumps layer; updates the cycle after advance.
// No backpressure of its own; the caller gates advance with its handshake.
module matrix_load_index_counter
  import matrix_load_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] size,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] layer,
  output logic             last_row
);

  assign last_row = (row == size - IDX_W'(1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      row   <= '0;
      layer <= '0;
    end else if (advance) begin
      if (last_row) begin
        row   <= '0;
        layer <= layer + IDX_W'(1);
      end else begin
        row <= row + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_load_scheduler.sv
// Weight-load sequencer: one storage write per accepted row, issued the cycle after the handshake; done 2 cycles after the last row.
// in_ready is high only in LOAD; optional stall timeout enabled by MATRIX_LOAD_TIMEOUT_EN.
module matrix_load_scheduler
  import matrix_load_pkg::*;
#(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LAYERS = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IDX_W-1:0]           num_layers,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [SIZE*DATA_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [IDX_W-1:0]           wr_layer,
  output logic [IDX_W-1:0]           wr_row,
  output logic [SIZE*DATA_WIDTH-1:0] wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  if (SIZE < 1 || MAX_LAYERS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("matrix_load_scheduler: SIZE, MAX_LAYERS and TIMEOUT must be positive");
  end

  state_t           state, state_n;
  logic [IDX_W-1:0] target;
  logic [IDX_W-1:0] row, layer;
  logic             last_row;
  logic             start_ok, hs, last_hs, timed_out;

  assign start_ok = (state == IDLE) && start;
  // abort wins over a coincident handshake, so the row is never written
  assign hs       = (state == LOAD) && in_valid && !abort;
  assign last_hs  = hs && last_row && (layer == target - IDX_W'(1));

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  matrix_load_index_counter u_index (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .advance  (hs),
    .size     (IDX_W'(SIZE)),
    .row      (row),
    .layer    (layer),
    .last_row (last_row)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (num_layers == '0) ? DONE : LOAD;
      LOAD: begin
        if (abort || timed_out) state_n = IDLE;
        else if (last_hs)       state_n = FLUSH;
      end
      FLUSH:   state_n = abort ? IDLE : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      target   <= '0;
      wr_en    <= 1'b0;
      wr_layer <= '0;
      wr_row   <= '0;
      wr_data  <= '0;
    end else begin
      if (start_ok) target <= clamp_layers(num_layers, IDX_W'(MAX_LAYERS));
      wr_en <= hs;
      if (hs) begin
        wr_layer <= layer;
        wr_row   <= row;
        wr_data  <= in_data;
      end
    end
  end

`ifdef MATRIX_LOAD_TIMEOUT_EN
  logic [IDX_W-1:0] stall_cnt;

  // fires on the TIMEOUT-th consecutive LOAD cycle without a handshake
  assign timed_out = (state == LOAD) && !hs && !abort &&
                     (stall_cnt == IDX_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      error     <= 1'b0;
    end else begin
      if (state != LOAD || hs) stall_cnt <= '0;
      else                     stall_cnt <= stall_cnt + IDX_W'(1);
      if (timed_out)     error <= 1'b1;
      else if (start_ok) error <= 1'b0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_load_scheduler.sv
// Self-checking bench for matrix_load_scheduler: table-driven random jobs plus reset/abort sequences.
module tb_matrix_load_scheduler;

  localparam int SIZE = 3;
  localparam int DW   = 32;
  localparam int MAXL = 4;
  localparam int RW   = SIZE * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   num_layers = '0;
  logic [RW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done, error;
  logic [31:0]   wr_layer, wr_row;
  logic [RW-1:0] wr_data;

  matrix_load_scheduler #(
    .SIZE(SIZE), .DATA_WIDTH(DW), .MAX_LAYERS(MAXL), .TIMEOUT(256)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_row(wr_row), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   layer;
    logic [31:0]   row;
    logic [RW-1:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    int          p_valid;
    int          exp_writes;
  } vec_t;

  wr_t           wr_q[$];
  logic [RW-1:0] acc_q[$];
  int cyc = 0;
  int done_cnt = 0, done_cyc = -1, last_acc_cyc = -1, start_cyc = -1, idle_cyc = -1;
  logic busy_prev = 1'b0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: rows the loader got accepted (spec rule: valid&ready, not aborted), writes, done pulses.
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back('{wr_layer, wr_row, wr_data});
    if (reset && in_valid && in_ready && !abort) begin
      acc_q.push_back(in_data);
      last_acc_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reset && start && !busy) start_cyc = cyc;
    if (busy_prev && !busy) idle_cyc = cyc;
    busy_prev = busy;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_q.delete();
    acc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    idle_cyc = -1;
  endtask

  // k-th accepted row of a job lands at layer k/SIZE, row k%SIZE with its own data
  task automatic check_writes(input string tag, input int n_w);
    for (int k = 0; k < n_w && k < wr_q.size() && k < acc_q.size(); k++) begin
      chk({tag, "_layer"}, wr_q[k].layer, 32'(k / SIZE));
      chk({tag, "_row"},   wr_q[k].row,   32'(k % SIZE));
      chk({tag, "_data"},  wr_q[k].data,  acc_q[k]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_en"},    wr_en, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_error"},    error, 0);
    chk({tag, "_wr_layer"}, wr_layer, 0);
    chk({tag, "_wr_row"},   wr_row, 0);
    chk({tag, "_wr_data"},  wr_data, 0);
  endtask

  task automatic run_job(input logic [31:0] n, input int p_valid, input int exp_w);
    int budget;
    clear_obs();
    start = 1'b1;
    num_layers = n;
    in_valid = 1'b0;
    step();
    start = 1'b0;
    budget = 0;
    while (busy && budget < 2000) begin
      in_valid = ($urandom_range(99) < p_valid);
      in_data  = {$urandom(), $urandom(), $urandom()};
      step();
      budget++;
    end
    in_valid = 1'b0;
    step();
    if (budget >= 2000) begin
      checks++;
      errors++;
      $display("FAIL job_budget n=%0d still busy after %0d cycles, required idle", n, budget);
    end
    chk("job_writes", wr_q.size(), exp_w);
    chk("job_accepts", acc_q.size(), exp_w);
    check_writes("job", exp_w);
    chk("job_done_cnt", done_cnt, 1);
    if (exp_w > 0) chk("job_done_latency", done_cyc - last_acc_cyc, 2);
    else           chk("job_done_latency0", done_cyc - start_cyc, 1);
    chk("job_busy_fall", idle_cyc - done_cyc, 1);
    chk("job_error", error, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd2,          100, 6};
    vecs[1] = '{32'd1,          50,  3};
    vecs[2] = '{32'd0,          50,  0};
    vecs[3] = '{32'd9,          70,  12};
    vecs[4] = '{32'd4,          30,  12};
    vecs[5] = '{32'd3,          100, 9};
    vecs[6] = '{32'hFFFF_FFFF,  80,  12};

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_job(vecs[i].n, vecs[i].p_valid, vecs[i].exp_writes);

    // Reset held low 3 cycles mid-LOAD, then a fresh job starts from layer 0 row 0
    clear_obs();
    start = 1'b1; num_layers = 32'd2; step(); start = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin in_data = {$urandom(), $urandom(), $urandom()}; step(); end
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    check_idle_outputs("midreset");
    reset = 1'b1;
    step();
    run_job(32'd1, 60, 3);

    // Abort after 4 accepted rows; a start during LOAD is ignored
    clear_obs();
    start = 1'b1; num_layers = 32'd3; step(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom(), $urandom(), $urandom()};
      start = (i == 1);
      num_layers = (i == 1) ? 32'd1 : 32'd3;
      step();
    end
    start = 1'b0;
    abort = 1'b1;
    in_data = {$urandom(), $urandom(), $urandom()};
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (8) begin in_data = {$urandom(), $urandom(), $urandom()}; step(); end
    in_valid = 1'b0;
    step();
    chk("abort_writes", wr_q.size(), 4);
    check_writes("abort", 4);
    chk("abort_done_cnt", done_cnt, 0);

    // Latency with in_valid held high, single layer
    run_job(32'd1, 100, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
